adc_pack_fifo: RTL

Parametrised single-clock packing FIFO for the ADC capture path: accepts narrow ADC samples, packs RATIO = OUT_W/IN_W consecutive samples into one wide word and buffers the words for the host-side stream reader. Generalises the fixed 8-to-32-bit capture FIFO with configurable widths, depth and lane order, plus flush of partial words, occupancy count and overflow accounting.

---
 rtl/adc_pack_pkg.sv | 28 ++
 rtl/sync_fifo_ram.sv | 48 ++++
 rtl/adc_pack_fifo.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/adc_pack_pkg.sv
// Shared sizing helpers and parameter legality rules for the ADC packing FIFO.
// Latency: n/a (elaboration-time constants and functions only).
// Backpressure: n/a.
package adc_pack_pkg;

    // Defaults for the standard 8-to-32 capture configuration.
    localparam int RATIO  = 4;
    localparam int LANE_W = $clog2(RATIO);
    localparam int PTR_W  = $clog2(512);
    localparam int CNT_W  = PTR_W + 1;

    // Number of samples packed into one output word.
    function automatic int ratio_of(input int in_w, input int out_w);
        return out_w / in_w;
    endfunction

    // Legal: OUT_W an integer multiple (>=2) of IN_W, DEPTH a power of two >= 4.
    function automatic bit params_ok(input int in_w, input int out_w, input int depth);
        return (in_w > 0) && (out_w % in_w == 0) && (out_w / in_w >= 2) &&
               (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

    // Bit-lane slot (in units of IN_W) that sample number 'lane' occupies.
    function automatic int lane_slot(input int lane, input int ratio, input bit lsb_first);
        return lsb_first ? lane : (ratio - 1 - lane);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port word store: one write port, one registered read port.
// Latency: read data appears one edge after re; write visible to a later read.
// Backpressure: none; the caller guarantees legal addresses and enables.
module sync_fifo_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_d, rdata_q;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data holds its last value unless a read is requested.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Registered read port; old contents are returned on a same-address write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adc_pack_fifo.sv
// Packs RATIO narrow ADC samples into one OUT_W word and queues words for the host.
// Latency: commit at edge N -> readable after N; read data one edge after rd_en.
// Backpressure: none upstream; a word committed into a full FIFO is dropped and counted.
module adc_pack_fifo
    import adc_pack_pkg::*;
#(
    parameter int              IN_W      = 8,
    parameter int              OUT_W     = 32,
    parameter int              DEPTH     = 512,
    parameter bit              LSB_FIRST = 1'b1,
    parameter logic [IN_W-1:0] PAD       = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IN_W-1:0]          din,
    input  logic                     wr_en,
    input  logic                     flush,
    input  logic                     rd_en,
    output logic [OUT_W-1:0]         dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int NLANE  = ratio_of(IN_W, OUT_W);
    localparam int LW     = $clog2(NLANE);
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;

    if (!params_ok(IN_W, OUT_W, DEPTH)) begin : g_bad_params
        $error("adc_pack_fifo: illegal IN_W/OUT_W/DEPTH combination");
    end

    logic [LW-1:0]    lane_d, lane_q;
    logic [OUT_W-1:0] shreg_d, shreg_q;
    logic [PW-1:0]    wptr_d, wptr_q;
    logic [PW-1:0]    rptr_d, rptr_q;
    logic [CW-1:0]    count_d, count_q;
    logic             full_d, full_q;
    logic             empty_d, empty_q;
    logic             dvld_d, dvld_q;
    logic             ovf_d, ovf_q;
    logic [15:0]      drop_d, drop_q;

    logic [LW:0]      fill_n;
    logic [OUT_W-1:0] cur_word;
    logic [OUT_W-1:0] commit_word;
    logic             commit_req;
    logic             commit_ok;
    logic             rd_acc;

    // Packer: slot the new sample, decide whether a word is committed, build it with PAD.
    always_comb begin
        int slot;
        cur_word    = shreg_q;
        commit_word = '0;
        slot        = lane_slot(int'(lane_q), NLANE, LSB_FIRST);
        if (wr_en) begin
            cur_word[slot*IN_W +: IN_W] = din;
        end
        fill_n     = {1'b0, lane_q} + (LW+1)'(wr_en);
        commit_req = (wr_en && (lane_q == LW'(NLANE - 1))) || (flush && (fill_n != '0));
        // Lanes beyond the fill level may hold stale samples from the previous word.
        for (int i = 0; i < NLANE; i++) begin
            slot = lane_slot(i, NLANE, LSB_FIRST);
            commit_word[slot*IN_W +: IN_W] = (i < int'(fill_n)) ? cur_word[slot*IN_W +: IN_W] : PAD;
        end
        shreg_d = cur_word;
        lane_d  = lane_q;
        if (commit_req) begin
            lane_d = '0;
        end else if (wr_en) begin
            lane_d = lane_q + LW'(1);
        end
    end

    // Queue control: a full FIFO still accepts a commit when a read frees a slot this cycle.
    always_comb begin
        rd_acc    = rd_en && !empty_q;
        commit_ok = commit_req && (!full_q || rd_acc);
        wptr_d    = wptr_q + PW'(commit_ok);
        rptr_d    = rptr_q + PW'(rd_acc);
        count_d   = count_q + CW'(commit_ok) - CW'(rd_acc);
        full_d    = (count_d == CW'(DEPTH));
        empty_d   = (count_d == '0);
        dvld_d    = rd_acc;
        ovf_d     = ovf_q;
        drop_d    = drop_q;
        if (commit_req && !commit_ok) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    // State registers; reset discards partial and buffered data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q  <= '0;
            shreg_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            dvld_q  <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            dvld_q  <= dvld_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    sync_fifo_ram #(
        .W     (OUT_W),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit_ok),
        .waddr (wptr_q),
        .wdata (commit_word),
        .re    (rd_acc),
        .raddr (rptr_q),
        .rdata (dout)
    );

    assign dout_valid = dvld_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign drop_cnt   = drop_q;

endmodule
